// File: rtl/axi_read_arbiter_pkg.sv
// Shared widths and helpers for the two-requester AXI read arbiter.
package axi_read_arbiter_pkg;

    localparam int LEN_W  = 8;
    localparam int SKIP_W = 4;

    function automatic logic [SKIP_W-1:0] sat_inc(input logic [SKIP_W-1:0] v,
                                                  input logic [SKIP_W-1:0] lim);
        return (v >= lim) ? lim : v + SKIP_W'(1);
    endfunction

endpackage

// File: rtl/axi_read_arbiter.sv
// Shares one AXI4 read channel between display DMA (req0, high priority) and
// the CPU L2 fill path (req1); one burst in flight, grant held to the last beat.
module axi_read_arbiter
    import axi_read_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,

    input  logic                  req0_arvalid,
    input  logic [ADDR_WIDTH-1:0] req0_araddr,
    input  logic [LEN_W-1:0]      req0_arlen,
    output logic                  req0_arready,
    output logic                  req0_rvalid,
    output logic [DATA_WIDTH-1:0] req0_rdata,
    input  logic                  req0_rready,

    input  logic                  req1_arvalid,
    input  logic [ADDR_WIDTH-1:0] req1_araddr,
    input  logic [LEN_W-1:0]      req1_arlen,
    output logic                  req1_arready,
    output logic                  req1_rvalid,
    output logic [DATA_WIDTH-1:0] req1_rdata,
    input  logic                  req1_rready,

    output logic                  mem_arvalid,
    output logic [ADDR_WIDTH-1:0] mem_araddr,
    output logic [LEN_W-1:0]      mem_arlen,
    input  logic                  mem_arready,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_rready,

    output logic                  grant_id
);

    // state | meaning
    // IDLE  | no burst owned; arbitrate among pending requesters
    // ADDR  | address of the granted requester presented to memory
    // DATA  | beats forwarded to the granted requester until the last one
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADDR = 2'd1;
    localparam logic [1:0] DATA = 2'd2;

    localparam logic [SKIP_W-1:0] SKIP_MAX = SKIP_W'(STARVE_LIMIT);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [LEN_W-1:0]  beat_count;
    logic [LEN_W-1:0]  latched_len;
    logic [SKIP_W-1:0] skip_count;

    logic any_req;
    logic win1;
    logic grant_rready;
    logic ar_hs;
    logic r_hs;
    logic last_beat;

    assign any_req = req0_arvalid | req1_arvalid;
    // req1 wins when req0 is quiet or when req0 has beaten it STARVE_LIMIT times running
    assign win1    = !req0_arvalid || ((skip_count == SKIP_MAX) && req1_arvalid);

    assign mem_arvalid  = (state == ADDR);
    assign mem_araddr   = grant_id ? req1_araddr : req0_araddr;
    assign mem_arlen    = grant_id ? req1_arlen  : req0_arlen;
    assign req0_arready = mem_arvalid && !grant_id && mem_arready;
    assign req1_arready = mem_arvalid &&  grant_id && mem_arready;

    assign grant_rready = grant_id ? req1_rready : req0_rready;
    assign mem_rready   = (state == DATA) && grant_rready;
    assign req0_rvalid  = (state == DATA) && !grant_id && mem_rvalid;
    assign req1_rvalid  = (state == DATA) &&  grant_id && mem_rvalid;
    assign req0_rdata   = mem_rdata;
    assign req1_rdata   = mem_rdata;

    assign ar_hs     = mem_arvalid && mem_arready;
    assign r_hs      = mem_rvalid && mem_rready;
    assign last_beat = r_hs && (beat_count == latched_len);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req)   state_nxt = ADDR;
            ADDR:    if (ar_hs)     state_nxt = DATA;
            DATA:    if (last_beat) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            grant_id    <= 1'b0;
            beat_count  <= '0;
            skip_count  <= '0;
            latched_len <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant_id   <= win1;
                        skip_count <= (!win1 && req1_arvalid) ? sat_inc(skip_count, SKIP_MAX)
                                                              : '0;
                    end
                end
                ADDR: begin
                    if (ar_hs) begin
                        latched_len <= mem_arlen;
                        beat_count  <= '0;
                    end
                end
                DATA: begin
                    // the wrap after beat 255 happens only once the burst has already exited
                    if (r_hs) beat_count <= beat_count + LEN_W'(1);
                end
                default: ;
            endcase
        end
    end

    a_grant_arvalid_held: assert property (@(posedge clk) disable iff (!reset_n)
        (state == ADDR) |-> (grant_id ? req1_arvalid : req0_arvalid));

    a_no_rvalid_outside_data: assert property (@(posedge clk) disable iff (!reset_n)
        (state != DATA) |-> !mem_rvalid);

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Randomized bench for axi_read_arbiter against a burst-level reference model.
module tb_axi_read_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LIM = 4;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    len;
    } burst_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          req0_arvalid, req1_arvalid;
    logic [AW-1:0] req0_araddr, req1_araddr;
    logic [7:0]    req0_arlen, req1_arlen;
    logic          req0_arready, req1_arready;
    logic          req0_rvalid, req1_rvalid;
    logic [DW-1:0] req0_rdata, req1_rdata;
    logic          req0_rready, req1_rready;
    logic          mem_arvalid;
    logic [AW-1:0] mem_araddr;
    logic [7:0]    mem_arlen;
    logic          mem_arready;
    logic          mem_rvalid;
    logic [DW-1:0] mem_rdata;
    logic          mem_rready;
    logic          grant_id;

    always #5 clk = ~clk;

    axi_read_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_arvalid(req0_arvalid), .req0_araddr(req0_araddr), .req0_arlen(req0_arlen),
        .req0_arready(req0_arready), .req0_rvalid(req0_rvalid), .req0_rdata(req0_rdata),
        .req0_rready(req0_rready),
        .req1_arvalid(req1_arvalid), .req1_araddr(req1_araddr), .req1_arlen(req1_arlen),
        .req1_arready(req1_arready), .req1_rvalid(req1_rvalid), .req1_rdata(req1_rdata),
        .req1_rready(req1_rready),
        .mem_arvalid(mem_arvalid), .mem_araddr(mem_araddr), .mem_arlen(mem_arlen),
        .mem_arready(mem_arready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .mem_rready(mem_rready),
        .grant_id(grant_id)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // requester queues, memory model and burst-level reference state
    burst_t q0[$];
    burst_t q1[$];
    int gap0 = 0, gap1 = 0;
    int p_arready = 100, p_rvalid = 100, p_rready = 100, p_gap = 0;
    int stall_armed = 0, stall_left = 0, stall_seen = 0;

    int m_phase = 0, m_grant = 0, m_skip = 0, m_len = 0, m_beat = 0;
    logic [AW-1:0] m_addr = '0;
    int mem_pending = 0, mem_idx = 0;
    logic [AW-1:0] mem_addr = '0;

    int grant_log[$];
    int done_beats[$];
    int beats_rx[2];

    function automatic logic [DW-1:0] beat_data(input logic [AW-1:0] a, input int i);
        return a ^ (DW'(i) * 32'h0101_0101) ^ 32'h5A00_0000;
    endfunction

    function automatic bit roll(input int p);
        return $urandom_range(99, 0) < p;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_grant = 0; m_skip = 0; m_beat = 0; m_len = 0;
        mem_pending = 0; mem_idx = 0;
    endtask

    task automatic clear_logs();
        grant_log.delete();
        done_beats.delete();
        beats_rx[0] = 0;
        beats_rx[1] = 0;
    endtask

    task automatic monitor_step();
        burst_t b;
        logic   rr_g;
        if (mem_arvalid && mem_arready) begin
            mem_pending = int'(mem_arlen) + 1;
            mem_addr    = mem_araddr;
            mem_idx     = 0;
        end else if (mem_rvalid && mem_rready && mem_pending > 0) begin
            mem_pending--;
            mem_idx++;
        end
        case (m_phase)
            0: begin
                check("idle_mem_arvalid", mem_arvalid, 0);
                check("idle_mem_rready", mem_rready, 0);
                check("idle_arready", {req0_arready, req1_arready}, 0);
                check("idle_rvalid", {req0_rvalid, req1_rvalid}, 0);
                if (req0_arvalid || req1_arvalid) begin
                    m_grant = (!req0_arvalid || (m_skip == LIM && req1_arvalid)) ? 1 : 0;
                    if (m_grant == 0 && req1_arvalid) m_skip = (m_skip < LIM) ? m_skip + 1 : LIM;
                    else                              m_skip = 0;
                    grant_log.push_back(m_grant);
                    m_phase = 1;
                end
            end
            1: begin
                b = '0;
                if (m_grant == 1 && q1.size() > 0) b = q1[0];
                if (m_grant == 0 && q0.size() > 0) b = q0[0];
                check("addr_mem_arvalid", mem_arvalid, 1);
                check("addr_grant_id", grant_id, m_grant);
                check("addr_araddr", mem_araddr, b.addr);
                check("addr_arlen", mem_arlen, b.len);
                check("addr_arready0", req0_arready, (m_grant == 0) && mem_arready);
                check("addr_arready1", req1_arready, (m_grant == 1) && mem_arready);
                check("addr_mem_rready", mem_rready, 0);
                if (mem_arready) begin
                    m_addr = b.addr;
                    m_len  = int'(b.len);
                    m_beat = 0;
                    m_phase = 2;
                    if (m_grant == 1) begin
                        if (q1.size() > 0) void'(q1.pop_front());
                        gap1 = $urandom_range(p_gap, 0);
                    end else begin
                        if (q0.size() > 0) void'(q0.pop_front());
                        gap0 = $urandom_range(p_gap, 0);
                    end
                end
            end
            default: begin
                rr_g = (m_grant == 1) ? req1_rready : req0_rready;
                check("data_mem_rready", mem_rready, rr_g);
                check("data_mem_arvalid", mem_arvalid, 0);
                check("data_grant_id", grant_id, m_grant);
                check("data_rvalid0", req0_rvalid, (m_grant == 0) && mem_rvalid);
                check("data_rvalid1", req1_rvalid, (m_grant == 1) && mem_rvalid);
                if (stall_armed != 0 && m_grant == 0 && m_beat == 3 && !req0_rready) begin
                    stall_seen++;
                    check("stall_beat_count", dut.beat_count, 3);
                end
                if (mem_rvalid && rr_g) begin
                    check("beat_rdata", (m_grant == 1) ? req1_rdata : req0_rdata,
                          beat_data(m_addr, m_beat));
                    check("beat_rdata_bcast", req0_rdata, req1_rdata);
                    m_beat++;
                    beats_rx[m_grant]++;
                    if (m_beat == m_len + 1) begin
                        done_beats.push_back(m_beat);
                        m_phase = 0;
                    end
                end
            end
        endcase
    endtask

    task automatic drive_step();
        if (!reset_n) begin
            req0_arvalid = 0; req1_arvalid = 0; req0_rready = 0; req1_rready = 0;
            mem_arready = 0; mem_rvalid = 0;
            return;
        end
        if (gap0 > 0) gap0--;
        if (gap1 > 0) gap1--;
        req0_arvalid = (q0.size() > 0) && (gap0 == 0);
        req1_arvalid = (q1.size() > 0) && (gap1 == 0);
        if (req0_arvalid) begin req0_araddr = q0[0].addr; req0_arlen = q0[0].len; end
        if (req1_arvalid) begin req1_araddr = q1[0].addr; req1_arlen = q1[0].len; end
        req1_rready = roll(p_rready);
        if (stall_armed != 0 && stall_left > 0 && m_phase == 2 && m_grant == 0 && m_beat == 3) begin
            req0_rready = 0;
            stall_left--;
        end else begin
            req0_rready = roll(p_rready);
        end
        mem_arready = roll(p_arready);
        mem_rvalid  = (mem_pending > 0) && roll(p_rvalid);
        mem_rdata   = mem_rvalid ? beat_data(mem_addr, mem_idx) : DW'($urandom);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) model_reset();
            else          monitor_step();
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            drive_step();
        end
    end

    task automatic wait_idle(input int budget, input string tag);
        int n;
        n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || m_phase != 0) && n < budget) begin
            @(posedge clk);
            #2;
            n++;
        end
        check({tag, "_done_in_budget"}, n < budget, 1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_arvalid"}, mem_arvalid, 0);
        check({tag, "_mem_rready"}, mem_rready, 0);
        check({tag, "_arready"}, {req0_arready, req1_arready}, 0);
        check({tag, "_rvalid"}, {req0_rvalid, req1_rvalid}, 0);
        check({tag, "_grant_id"}, grant_id, 0);
    endtask

    int exp_seq[12] = '{0, 0, 0, 0, 1, 0, 0, 1, 1, 1, 1, 1};
    int exp_rx[2];
    int n_rand;
    int poll;

    initial begin
        reset_n = 0;
        req0_arvalid = 0; req0_araddr = '0; req0_arlen = '0; req0_rready = 0;
        req1_arvalid = 0; req1_araddr = '0; req1_arlen = '0; req1_rready = 0;
        mem_arready = 0; mem_rvalid = 0; mem_rdata = '0;
        clear_logs();
        repeat (3) @(posedge clk);
        #2;
        check_outputs_zero("reset");
        reset_n = 1;
        @(posedge clk);
        #2;

        // solo requester 1
        clear_logs();
        q1.push_back('{addr: 32'h1000, len: 8'd3});
        wait_idle(100, "solo");
        check("solo_grant_count", grant_log.size(), 1);
        if (grant_log.size() > 0) check("solo_grant", grant_log[0], 1);
        check("solo_beats_req1", beats_rx[1], 4);
        check("solo_beats_req0", beats_rx[0], 0);
        check("solo_grant_id", grant_id, 1);

        // simultaneous requests
        clear_logs();
        q0.push_back('{addr: 32'h2000, len: 8'd63});
        q1.push_back('{addr: 32'h3000, len: 8'd7});
        wait_idle(500, "simul");
        check("simul_grant_count", grant_log.size(), 2);
        if (grant_log.size() == 2) begin
            check("simul_first", grant_log[0], 0);
            check("simul_second", grant_log[1], 1);
        end
        if (done_beats.size() == 2) begin
            check("simul_beats_first", done_beats[0], 64);
            check("simul_beats_second", done_beats[1], 8);
        end

        // starvation guard with both requesters continuously pending
        clear_logs();
        p_rready = 70; p_rvalid = 70; p_arready = 70;
        for (int i = 0; i < 6; i++) begin
            q0.push_back('{addr: 32'h4000 + 32'(i * 256), len: 8'($urandom_range(3, 0))});
            q1.push_back('{addr: 32'h8000 + 32'(i * 256), len: 8'($urandom_range(3, 0))});
        end
        wait_idle(3000, "starve");
        check("starve_grant_count", grant_log.size(), 12);
        for (int i = 0; i < 12; i++) begin
            if (i < grant_log.size()) check($sformatf("starve_seq_%0d", i), grant_log[i], exp_seq[i]);
        end

        // backpressure on beat 3
        clear_logs();
        p_rready = 100; p_rvalid = 100; p_arready = 100;
        stall_armed = 1; stall_left = 5; stall_seen = 0;
        q0.push_back('{addr: 32'h5000, len: 8'd7});
        wait_idle(200, "stall");
        stall_armed = 0;
        check("stall_cycles", stall_seen, 5);
        check("stall_beats", beats_rx[0], 8);

        // edge lengths
        clear_logs();
        q0.push_back('{addr: 32'h6000, len: 8'd0});
        wait_idle(100, "len0");
        check("len0_beats", beats_rx[0], 1);
        clear_logs();
        q1.push_back('{addr: 32'h7000, len: 8'd255});
        wait_idle(1000, "len255");
        check("len255_beats", beats_rx[1], 256);
        check("len255_bursts", done_beats.size(), 1);

        // reset in the middle of a burst
        clear_logs();
        q0.push_back('{addr: 32'h9000, len: 8'd63});
        poll = 0;
        while (!(m_phase == 2 && m_beat == 10) && poll < 500) begin
            @(posedge clk);
            #2;
            poll++;
        end
        check("midrst_reached_beat10", poll < 500, 1);
        reset_n = 0;
        q0.delete();
        q1.delete();
        mem_pending = 0;
        #1;
        check_outputs_zero("midrst");
        repeat (2) @(posedge clk);
        #2;
        check("midrst_skip", dut.skip_count, 0);
        check_outputs_zero("midrst_hold");
        reset_n = 1;
        @(posedge clk);
        #2;
        clear_logs();
        q1.push_back('{addr: 32'hA000, len: 8'd3});
        wait_idle(100, "postrst");
        check("postrst_grant_count", grant_log.size(), 1);
        if (grant_log.size() > 0) check("postrst_grant", grant_log[0], 1);
        check("postrst_beats", beats_rx[1], 4);

        // randomized traffic
        clear_logs();
        p_rready = 70; p_rvalid = 70; p_arready = 60; p_gap = 3;
        exp_rx[0] = 0;
        exp_rx[1] = 0;
        n_rand = 40;
        for (int i = 0; i < n_rand; i++) begin
            burst_t b;
            b.addr = AW'($urandom) & 32'hFFFF_FFF0;
            b.len  = 8'($urandom_range(15, 0));
            if ($urandom_range(1, 0) == 1) begin q1.push_back(b); exp_rx[1] += int'(b.len) + 1; end
            else                           begin q0.push_back(b); exp_rx[0] += int'(b.len) + 1; end
        end
        wait_idle(20000, "rand");
        check("rand_bursts", done_beats.size(), n_rand);
        check("rand_beats_req0", beats_rx[0], exp_rx[0]);
        check("rand_beats_req1", beats_rx[1], exp_rx[1]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
